// File: rtl/sdr_app_arbiter_if.sv
// Requester-side and controller-side signal bundle of the SDRAM application-port arbiter.
// master = arbiter view; slave = requesters plus controller view.
interface sdr_app_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned aw   = 26,
  parameter int unsigned dw   = 32,
  parameter int unsigned bl   = 5
);
  logic [NREQ-1:0]    rq_req;
  logic [NREQ*aw-1:0] rq_addr;
  logic [NREQ*bl-1:0] rq_len;
  logic [NREQ-1:0]    rq_wr_n;
  logic [NREQ*dw-1:0] rq_wr_data;
  logic [NREQ-1:0]    rq_ack;
  logic [NREQ-1:0]    rq_wr_next;
  logic [NREQ-1:0]    rq_rd_valid;
  logic [dw-1:0]      rq_rd_data;
  logic [NREQ-1:0]    rq_done;

  logic               app_req;
  logic [aw-1:0]      app_req_addr;
  logic [bl-1:0]      app_req_len;
  logic               app_req_wr_n;
  logic               app_req_ack;
  logic [dw-1:0]      app_wr_data;
  logic               app_wr_next_req;
  logic [dw-1:0]      app_rd_data;
  logic               app_rd_valid;
  logic               app_last_wr;
  logic               app_last_rd;

  modport master (
    input  rq_req, rq_addr, rq_len, rq_wr_n, rq_wr_data,
    input  app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid, app_last_wr, app_last_rd,
    output rq_ack, rq_wr_next, rq_rd_valid, rq_rd_data, rq_done,
    output app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data
  );

  modport slave (
    output rq_req, rq_addr, rq_len, rq_wr_n, rq_wr_data,
    output app_req_ack, app_wr_next_req, app_rd_data, app_rd_valid, app_last_wr, app_last_rd,
    input  rq_ack, rq_wr_next, rq_rd_valid, rq_rd_data, rq_done,
    input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_wr_data
  );
endinterface

// File: rtl/sdr_app_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller application port among NREQ requesters.
// Ownership is held for a whole burst, from grant until the last beat or a watchdog abort.
module sdr_app_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned aw   = 26,
  parameter int unsigned dw   = 32,
  parameter int unsigned bl   = 5,
  parameter int unsigned TMO  = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  sdr_app_arbiter_if.master bus,
  output logic [2:0]        owner,
  output logic              tmo_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWdata, StRdata} state_e;

  state_e        state_q, state_d;
  logic [2:0]    owner_q;
  logic [2:0]    ptr_q;
  logic [2:0]    ptr_next;
  logic [aw-1:0] addr_q;
  logic [bl-1:0] len_q;
  logic          wr_n_q;
  logic [15:0]   cnt_q;
  logic          tmo_err_q;

  logic          grant_found;
  logic [2:0]    grant_idx;
  logic [aw-1:0] grant_addr;
  logic [bl-1:0] grant_len;
  logic          grant_wr_n;

  logic          tmo_hit;
  logic          live;
  logic          ack_evt;
  logic          wr_ph;
  logic          rd_ph;
  logic          last_evt;

  // Search starts at ptr and wraps; the first requester found in that order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_addr  = '0;
    grant_len   = '0;
    grant_wr_n  = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!grant_found && bus.rq_req[j] && (((32'(ptr_q) + i) % NREQ) == j)) begin
          grant_found = 1'b1;
          grant_idx   = 3'(j);
          grant_addr  = bus.rq_addr[j*aw +: aw];
          grant_len   = bus.rq_len[j*bl +: bl];
          grant_wr_n  = bus.rq_wr_n[j];
        end
      end
    end
  end

  assign ptr_next = (owner_q == 3'(NREQ - 1)) ? 3'd0 : owner_q + 3'd1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) state_d = StReq;
      end
      StReq: begin
        if (tmo_hit) begin
          state_d = StIdle;
        end else if (ack_evt) begin
          // A last beat coinciding with the ack completes the burst at once.
          if (last_evt)    state_d = StIdle;
          else if (wr_n_q) state_d = StRdata;
          else             state_d = StWdata;
        end
      end
      StWdata, StRdata: begin
        if (tmo_hit || last_evt) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Events and port outputs; everything requester-facing is gated off during reset
  // and in the watchdog cycle so an aborted owner never sees an ack or done.
  always_comb begin
    tmo_hit  = (state_q != StIdle) && (cnt_q == 16'(TMO));
    live     = !wb_rst_i && !tmo_hit;
    ack_evt  = live && (state_q == StReq) && bus.app_req_ack;
    wr_ph    = live && !wr_n_q && ((state_q == StWdata) || ack_evt);
    rd_ph    = live && wr_n_q && ((state_q == StRdata) || ack_evt);
    last_evt = (wr_ph && bus.app_last_wr) ||
               (rd_ph && bus.app_rd_valid && bus.app_last_rd);

    bus.app_req      = live && (state_q == StReq) && !bus.app_req_ack;
    bus.app_req_addr = addr_q;
    bus.app_req_len  = len_q;
    bus.app_req_wr_n = wr_n_q;
    bus.rq_rd_data   = bus.app_rd_data;

    bus.app_wr_data  = '0;
    bus.rq_ack       = '0;
    bus.rq_wr_next   = '0;
    bus.rq_rd_valid  = '0;
    bus.rq_done      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == 3'(i)) begin
        bus.app_wr_data    = bus.rq_wr_data[i*dw +: dw];
        bus.rq_ack[i]      = ack_evt;
        bus.rq_wr_next[i]  = wr_ph && bus.app_wr_next_req;
        bus.rq_rd_valid[i] = rd_ph && bus.app_rd_valid;
        bus.rq_done[i]     = last_evt;
      end
    end

    owner   = (state_q == StIdle) ? 3'd0 : owner_q;
    tmo_err = tmo_err_q;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      owner_q   <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      wr_n_q    <= 1'b0;
      cnt_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        cnt_q <= '0;
        if (grant_found) begin
          owner_q <= grant_idx;
          addr_q  <= grant_addr;
          len_q   <= grant_len;
          wr_n_q  <= grant_wr_n;
        end
      end else begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (ack_evt || tmo_hit) ptr_q <= ptr_next;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdr_app_arbiter.sv
// Bench for sdr_app_arbiter: table-driven bursts, scoreboarded ack/done pulses,
// plus hand-written watchdog and mid-burst reset sequences.
module tb_sdr_app_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 26;
  localparam int unsigned DW   = 32;
  localparam int unsigned BL   = 5;
  localparam int unsigned TMO  = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] owner;
  logic       tmo_err;

  sdr_app_arbiter_if #(.NREQ(NREQ), .aw(AW), .dw(DW), .bl(BL)) bus ();

  sdr_app_arbiter #(.NREQ(NREQ), .aw(AW), .dw(DW), .bl(BL), .TMO(TMO)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus),
    .owner   (owner),
    .tmo_err (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    idx;
    logic [AW-1:0] addr;
    logic [BL-1:0] len;
    logic          wr_n;
  } ack_exp_t;

  typedef struct {
    logic [NREQ-1:0] mask;
    logic            wr_n;
    int unsigned     exp;
    int unsigned     beats;
    int unsigned     ack_dly;
    bit              lastack;
  } vec_t;

  ack_exp_t      ack_q[$];
  int unsigned   done_q[$];
  logic [AW-1:0] addr_tab[NREQ];
  logic [BL-1:0] len_tab[NREQ];
  vec_t          vt[10];
  int            n_run  = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops expectations whenever the DUT pulses an ack or a done.
  task automatic monitor();
    ack_exp_t    e;
    int unsigned d;
    if (bus.rq_ack != '0) begin
      if (ack_q.size() == 0) begin
        chk("ack_unexpected", 64'(bus.rq_ack), 64'(0));
      end else begin
        e = ack_q.pop_front();
        chk("sb_ack_vec", 64'(bus.rq_ack), 64'(1) << e.idx);
        chk("sb_ack_addr", 64'(bus.app_req_addr), 64'(e.addr));
        chk("sb_ack_len", 64'(bus.app_req_len), 64'(e.len));
        chk("sb_ack_wr_n", 64'(bus.app_req_wr_n), 64'(e.wr_n));
      end
    end
    if (bus.rq_done != '0) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 64'(bus.rq_done), 64'(0));
      end else begin
        d = done_q.pop_front();
        chk("sb_done_vec", 64'(bus.rq_done), 64'(1) << d);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    bus.app_req_ack     = 1'b0;
    bus.app_wr_next_req = 1'b0;
    bus.app_rd_valid    = 1'b0;
    bus.app_last_wr     = 1'b0;
    bus.app_last_rd     = 1'b0;
  endtask

  task automatic smp();
    #2;
    monitor();
  endtask

  task automatic drive_fields(input logic wr_n);
    for (int i = 0; i < NREQ; i++) begin
      bus.rq_addr[i*AW +: AW]    = addr_tab[i];
      bus.rq_len[i*BL +: BL]     = len_tab[i];
      bus.rq_wr_data[i*DW +: DW] = 32'hD000_0000 + 32'(i);
    end
    bus.rq_wr_n = {NREQ{wr_n}};
  endtask

  function automatic logic [DW-1:0] beat_data(input logic wr_n, input int unsigned exp,
                                              input int unsigned b);
    if (!wr_n) return 32'hA5A5_0000 + 32'(b);
    return 32'h5A00_0000 + (32'(exp) << 8) + 32'(b);
  endfunction

  task automatic strobes_all();
    bus.app_wr_next_req = 1'b1;
    bus.app_rd_valid    = 1'b1;
    bus.app_last_wr     = 1'b1;
    bus.app_last_rd     = 1'b1;
  endtask

  task automatic drive_beat(input logic wr_n, input int unsigned exp, input int unsigned b,
                            input bit last);
    if (!wr_n) begin
      bus.app_wr_next_req            = 1'b1;
      bus.app_last_wr                = last;
      bus.rq_wr_data[exp*DW +: DW]   = beat_data(wr_n, exp, b);
    end else begin
      bus.app_rd_valid = 1'b1;
      bus.app_last_rd  = last;
      bus.app_rd_data  = beat_data(wr_n, exp, b);
    end
  endtask

  task automatic check_beat(input logic wr_n, input int unsigned exp, input int unsigned b,
                            input bit last);
    if (!wr_n) begin
      chk("wr_next_route", 64'(bus.rq_wr_next), 64'(1) << exp);
      chk("wr_data_mux", 64'(bus.app_wr_data), 64'(beat_data(wr_n, exp, b)));
      chk("wr_no_rd_valid", 64'(bus.rq_rd_valid), 64'(0));
    end else begin
      chk("rd_valid_route", 64'(bus.rq_rd_valid), 64'(1) << exp);
      chk("rd_data", 64'(bus.rq_rd_data), 64'(beat_data(wr_n, exp, b)));
      chk("rd_no_wr_next", 64'(bus.rq_wr_next), 64'(0));
    end
    chk("done_pulse", 64'(bus.rq_done), last ? (64'(1) << exp) : 64'(0));
  endtask

  task automatic run_burst(input logic [NREQ-1:0] mask, input logic wr_n, input int unsigned exp,
                           input int unsigned beats, input int unsigned ack_dly,
                           input bit lastack, input bit drop);
    ack_exp_t e;
    cyc();
    bus.rq_req = mask;
    drive_fields(wr_n);
    strobes_all();
    e.idx  = 3'(exp);
    e.addr = addr_tab[exp];
    e.len  = len_tab[exp];
    e.wr_n = wr_n;
    ack_q.push_back(e);
    smp();
    chk("idle_owner", 64'(owner), 64'(0));
    chk("idle_app_req", 64'(bus.app_req), 64'(0));
    chk("idle_no_route", 64'({bus.rq_wr_next, bus.rq_rd_valid, bus.rq_done}), 64'(0));
    for (int unsigned k = 0; k < ack_dly; k++) begin
      cyc();
      strobes_all();
      smp();
      chk("req_app_req", 64'(bus.app_req), 64'(1));
      chk("req_owner", 64'(owner), 64'(exp));
      chk("req_strobes_ignored", 64'({bus.rq_ack, bus.rq_wr_next, bus.rq_rd_valid, bus.rq_done}),
          64'(0));
    end
    cyc();
    bus.app_req_ack = 1'b1;
    if (lastack) begin
      drive_beat(wr_n, exp, 0, 1'b1);
      done_q.push_back(exp);
    end
    smp();
    chk("ack_pulse", 64'(bus.rq_ack), 64'(1) << exp);
    chk("ack_app_req_low", 64'(bus.app_req), 64'(0));
    if (lastack) begin
      check_beat(wr_n, exp, 0, 1'b1);
    end else begin
      chk("ack_no_done", 64'(bus.rq_done), 64'(0));
      for (int unsigned b = 0; b < beats; b++) begin
        cyc();
        if (drop && b == 0) bus.rq_req = '0;
        drive_beat(wr_n, exp, b, b == beats - 1);
        if (b == beats - 1) done_q.push_back(exp);
        smp();
        chk("data_owner", 64'(owner), 64'(exp));
        check_beat(wr_n, exp, b, b == beats - 1);
      end
    end
  endtask

  initial begin
    ack_exp_t e;
    rst                 = 1'b1;
    bus.rq_req          = '0;
    bus.rq_addr         = '0;
    bus.rq_len          = '0;
    bus.rq_wr_n         = '0;
    bus.rq_wr_data      = '0;
    bus.app_req_ack     = 1'b0;
    bus.app_wr_next_req = 1'b0;
    bus.app_rd_data     = '0;
    bus.app_rd_valid    = 1'b0;
    bus.app_last_wr     = 1'b0;
    bus.app_last_rd     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      addr_tab[i] = 26'h000_0100 + 26'(i) * 26'h001_0000;
      len_tab[i]  = 5'd1;
    end

    vt[0] = '{4'b0011, 1'b0, 0, 2, 0, 1'b0};
    vt[1] = '{4'b0011, 1'b1, 1, 3, 1, 1'b0};
    vt[2] = '{4'b0011, 1'b0, 0, 1, 2, 1'b0};
    vt[3] = '{4'b1100, 1'b1, 2, 2, 0, 1'b0};
    vt[4] = '{4'b1100, 1'b0, 3, 3, 1, 1'b0};
    vt[5] = '{4'b1010, 1'b1, 1, 1, 0, 1'b0};
    vt[6] = '{4'b1010, 1'b0, 3, 2, 2, 1'b0};
    vt[7] = '{4'b1111, 1'b1, 0, 1, 0, 1'b1};
    vt[8] = '{4'b0100, 1'b0, 2, 1, 1, 1'b1};
    vt[9] = '{4'b1001, 1'b1, 3, 2, 0, 1'b0};

    // Reset state
    repeat (3) begin cyc(); smp(); end
    cyc();
    rst = 1'b0;
    smp();
    chk("rst_app_req", 64'(bus.app_req), 64'(0));
    chk("rst_owner", 64'(owner), 64'(0));
    chk("rst_tmo_err", 64'(tmo_err), 64'(0));
    chk("rst_rq_outs", 64'({bus.rq_ack, bus.rq_wr_next, bus.rq_rd_valid, bus.rq_done}), 64'(0));

    // Rotation with all four held: 0,1,2,3,0
    for (int k = 0; k < 5; k++) run_burst(4'b1111, 1'b1, k % 4, 1, 0, 1'b0, 1'b0);

    // Single read, requester 0, len 4, ack on the third request cycle
    len_tab[0] = 5'd4;
    len_tab[2] = 5'd8;
    len_tab[3] = 5'd3;
    run_burst(4'b0001, 1'b1, 0, 4, 2, 1'b0, 1'b1);
    // Write routing on requester 2, 8 beats
    run_burst(4'b0100, 1'b0, 2, 8, 1, 1'b0, 1'b1);
    // Ack, read beat and last all in one cycle; IDLE the cycle after
    run_burst(4'b1000, 1'b1, 3, 1, 0, 1'b1, 1'b1);
    cyc();
    bus.rq_req = '0;
    smp();
    chk("t4_idle_owner", 64'(owner), 64'(0));
    chk("t4_idle_app_req", 64'(bus.app_req), 64'(0));

    for (int v = 0; v < 10; v++) begin
      run_burst(vt[v].mask, vt[v].wr_n, vt[v].exp, vt[v].beats, vt[v].ack_dly, vt[v].lastack,
                1'b1);
    end

    // Watchdog after ack on requester 1; requester 3 waits and is served next
    cyc();
    bus.rq_req = 4'b1010;
    drive_fields(1'b0);
    e.idx  = 3'd1;
    e.addr = addr_tab[1];
    e.len  = len_tab[1];
    e.wr_n = 1'b0;
    ack_q.push_back(e);
    smp();
    cyc();
    bus.app_req_ack = 1'b1;
    smp();
    chk("wd_ack", 64'(bus.rq_ack), 64'(2));
    for (int k = 1; k <= 16; k++) begin
      cyc();
      bus.rq_req = 4'b1000;
      smp();
      if (k == 15) chk("wd_owner_held", 64'(owner), 64'(1));
      if (k == 15) chk("wd_err_early", 64'(tmo_err), 64'(0));
    end
    chk("wd_err_at_hit", 64'(tmo_err), 64'(0));
    chk("wd_no_done", 64'(bus.rq_done), 64'(0));
    chk("wd_app_req", 64'(bus.app_req), 64'(0));
    cyc();
    smp();
    chk("wd_err_set", 64'(tmo_err), 64'(1));
    chk("wd_idle_owner", 64'(owner), 64'(0));
    cyc();
    bus.rq_req = '0;
    smp();
    chk("wd_next_owner", 64'(owner), 64'(3));
    chk("wd_next_app_req", 64'(bus.app_req), 64'(1));
    // Requester 3 is never acked: app_req must drop at the limit
    for (int k = 1; k <= 16; k++) begin
      cyc();
      smp();
      if (k == 15) chk("wd2_app_req_held", 64'(bus.app_req), 64'(1));
    end
    chk("wd2_app_req_drop", 64'(bus.app_req), 64'(0));
    chk("wd2_no_ack", 64'(bus.rq_ack), 64'(0));
    cyc();
    smp();
    chk("wd2_idle_owner", 64'(owner), 64'(0));
    chk("wd2_err_sticky", 64'(tmo_err), 64'(1));

    // Reset during a write burst of requester 2 (ptr would be 3 without reset)
    cyc();
    bus.rq_req = 4'b0100;
    drive_fields(1'b0);
    e.idx  = 3'd2;
    e.addr = addr_tab[2];
    e.len  = len_tab[2];
    e.wr_n = 1'b0;
    ack_q.push_back(e);
    smp();
    cyc();
    bus.app_req_ack = 1'b1;
    smp();
    cyc();
    bus.rq_req = '0;
    drive_beat(1'b0, 2, 0, 1'b0);
    smp();
    chk("t6_wr_next", 64'(bus.rq_wr_next), 64'(4));
    cyc();
    rst = 1'b1;
    drive_beat(1'b0, 2, 1, 1'b1);
    smp();
    chk("t6_rst_no_done", 64'(bus.rq_done), 64'(0));
    cyc();
    rst = 1'b0;
    smp();
    chk("t6_owner", 64'(owner), 64'(0));
    chk("t6_app_req", 64'(bus.app_req), 64'(0));
    chk("t6_tmo_err", 64'(tmo_err), 64'(0));
    chk("t6_no_done", 64'(bus.rq_done), 64'(0));
    // ptr back at 0: with everyone requesting, requester 0 wins
    run_burst(4'b1111, 1'b1, 0, 1, 0, 1'b0, 1'b1);

    cyc();
    smp();
    chk("sb_ack_drained", 64'(ack_q.size()), 64'(0));
    chk("sb_done_drained", 64'(done_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
